// File: rtl/ms_timer_pkg.sv
// ms_timer_pkg: shared state encoding and default widths for the millisecond timer
package ms_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} timer_state_t;
    localparam int TIMER_W_DEF = 16;
    localparam int EXP_W_DEF = 8;
endpackage

// File: rtl/ms_timer_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at its maximum value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;
    // clear and increment together yield 1, so a zero-length interval counts its own expiry
    always_comb count_d = clr_i ? W'(inc_i) : (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;
    // count register
    always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
    assign count_o = count_q;
endmodule

// File: rtl/ms_timer.sv
// ms_timer: millisecond countdown timer with one-shot/periodic modes, pause and abort
module ms_timer
    import ms_timer_pkg::*;
#(
    parameter int TIMER_W = TIMER_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ms_tick,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               periodic,
    input  logic [TIMER_W-1:0] load_val,
    output logic               busy,
    output logic               expired,
    output logic [TIMER_W-1:0] remaining,
    output logic [EXP_W-1:0]   exp_count
);
    timer_state_t state_q, state_d;
    logic [TIMER_W-1:0] rem_q, rem_d, reload_q, reload_d;
    logic per_q, per_d, exp_q, exp_d, clr, inc;
    // next-state logic; stop outranks start, which outranks a tick
    always_comb begin
        state_d = state_q;
        rem_d = rem_q;
        reload_d = reload_q;
        per_d = per_q;
        exp_d = 1'b0;
        clr = 1'b0;
        inc = 1'b0;
        if (stop) begin
            state_d = IDLE;
            rem_d = '0;
        end else if (start) begin
            rem_d = load_val;
            reload_d = load_val;
            per_d = periodic;
            clr = 1'b1;
            exp_d = load_val == '0;
            inc = load_val == '0;
            state_d = load_val == '0 ? IDLE : RUN;
        end else if (state_q == RUN) begin
            if (pause) begin
                state_d = HOLD;
            end else if (ms_tick) begin
                if (rem_q > TIMER_W'(1)) begin
                    rem_d = rem_q - 1'b1;
                end else begin
                    exp_d = 1'b1;
                    inc = 1'b1;
                    rem_d = per_q ? reload_q : '0;
                    state_d = per_q ? RUN : IDLE;
                end
            end
        end else if (state_q == HOLD && !pause) begin
            state_d = RUN;
        end
    end
    // state and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q <= '0;
            reload_q <= '0;
            per_q <= 1'b0;
            exp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q <= rem_d;
            reload_q <= reload_d;
            per_q <= per_d;
            exp_q <= exp_d;
        end
    end
    sat_counter #(.W(EXP_W)) u_exp_cnt (
        .clk(clk),
        .rst(rst),
        .clr_i(clr),
        .inc_i(inc),
        .count_o(exp_count)
    );
    assign busy = state_q != IDLE;
    assign expired = exp_q;
    assign remaining = rem_q;
endmodule

// File: tb/tb_ms_timer.sv
// tb_ms_timer: directed and random stimulus checked against a behavioural timer model
module tb_ms_timer;
    localparam int TW = 16;
    localparam int EW = 8;
    localparam int EMAX = (1 << EW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b0, ms_tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
    logic [TW-1:0] load_val = '0;
    logic busy, expired;
    logic [TW-1:0] remaining;
    logic [EW-1:0] exp_count;
    int total = 0, bad = 0;
    bit m_busy, m_held, m_per, m_exp;
    int m_left, m_reload, m_cnt;

    ms_timer #(.TIMER_W(TW), .EXP_W(EW)) dut (
        .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start), .stop(stop),
        .pause(pause), .periodic(periodic), .load_val(load_val),
        .busy(busy), .expired(expired), .remaining(remaining), .exp_count(exp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // behavioural view: a timer counting whole ticks down, with an on/paused flag
    task automatic model_update();
        m_exp = 1'b0;
        if (rst) begin
            m_busy = 0; m_held = 0; m_left = 0; m_reload = 0; m_per = 0; m_cnt = 0;
        end else if (stop) begin
            m_busy = 0; m_held = 0; m_left = 0;
        end else if (start) begin
            m_left = int'(load_val); m_reload = int'(load_val); m_per = periodic; m_held = 0;
            m_busy = load_val != 0;
            m_exp = load_val == 0;
            m_cnt = (load_val == 0) ? 1 : 0;
        end else if (m_busy && !m_held) begin
            if (pause) m_held = 1;
            else if (ms_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_exp = 1;
                    m_cnt = (m_cnt + 1 > EMAX) ? EMAX : m_cnt + 1;
                    if (m_per) m_left = m_reload;
                    else m_busy = 0;
                end
            end
        end else if (m_busy && !pause) begin
            m_held = 0;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("remaining", 32'(remaining), 32'(m_left));
        chk("exp_count", 32'(exp_count), 32'(m_cnt));
        rst = 0; start = 0; stop = 0; ms_tick = 0;
    endtask

    task automatic do_start(input int val, input bit per);
        load_val = TW'(val); periodic = per; start = 1;
        step();
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1;
            step();
            repeat (gap - 1) step();
        end
    endtask

    initial begin
        rst = 1; step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rem", 32'(remaining), 0);
        chk("rst_cnt", 32'(exp_count), 0);
        // one-shot of 3
        do_start(3, 0);
        chk("os_rem3", 32'(remaining), 3);
        for (int i = 1; i <= 3; i++) begin
            ms_tick = 1; step();
            chk("os_rem", 32'(remaining), 32'(3 - i));
            chk("os_exp", 32'(expired), 32'(i == 3));
            repeat (9) step();
        end
        chk("os_busy", 32'(busy), 0);
        chk("os_cnt", 32'(exp_count), 1);
        // periodic of 2, seven ticks
        do_start(2, 1);
        ticks(7, 3);
        chk("per_rem", 32'(remaining), 1);
        chk("per_cnt", 32'(exp_count), 3);
        chk("per_busy", 32'(busy), 1);
        stop = 1; step();
        // pause mid-interval
        do_start(5, 0);
        ticks(2, 2);
        pause = 1; step();
        ticks(3, 2);
        chk("pause_rem", 32'(remaining), 3);
        pause = 0; step();
        ticks(2, 2);
        chk("pause_busy", 32'(busy), 1);
        ms_tick = 1; step();
        chk("pause_exp", 32'(expired), 1);
        step();
        // stop colliding with the final tick
        do_start(1, 0);
        stop = 1; ms_tick = 1; step();
        chk("stopcol_exp", 32'(expired), 0);
        chk("stopcol_rem", 32'(remaining), 0);
        chk("stopcol_busy", 32'(busy), 0);
        // start colliding with the final tick
        do_start(1, 0);
        load_val = 4; start = 1; ms_tick = 1; step();
        chk("startcol_rem", 32'(remaining), 4);
        chk("startcol_exp", 32'(expired), 0);
        // stop together with start
        load_val = 7; start = 1; stop = 1; step();
        chk("ss_busy", 32'(busy), 0);
        chk("ss_rem", 32'(remaining), 0);
        // zero-length interval
        do_start(0, 0);
        chk("zero_exp", 32'(expired), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_cnt", 32'(exp_count), 1);
        step();
        chk("zero_busy2", 32'(busy), 0);
        // maximum interval
        do_start(65535, 0);
        ms_tick = 1;
        for (int i = 0; i < 65534; i++) begin ms_tick = 1; step(); end
        chk("max_rem", 32'(remaining), 1);
        ms_tick = 1; step();
        chk("max_exp", 32'(expired), 1);
        // expiry counter saturation
        do_start(1, 1);
        for (int i = 0; i < 300; i++) begin ms_tick = 1; step(); end
        chk("sat_cnt", 32'(exp_count), 255);
        stop = 1; step();
        // reset mid-run
        do_start(10, 0);
        ticks(4, 2);
        rst = 1; step();
        chk("rstrun_rem", 32'(remaining), 0);
        chk("rstrun_exp", 32'(expired), 0);
        ticks(5, 2);
        chk("rstrun_busy", 32'(busy), 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            ms_tick = $urandom_range(3) == 0;
            start = $urandom_range(39) == 0;
            stop = $urandom_range(79) == 0;
            rst = $urandom_range(499) == 0;
            if ($urandom_range(29) == 0) pause = ~pause;
            periodic = $urandom_range(1);
            load_val = ($urandom_range(9) == 0) ? TW'($urandom) : TW'($urandom_range(6));
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
